// File: rtl/bit_serial_logic_unit.sv
// bit_serial_logic_unit
//   Bit-serial bitwise logic unit. One operand pair and an opcode are taken
//   over a valid/ready handshake. The selected operation is then evaluated one
//   bit per clock, LSB first, through a single one-bit gate slice. The WIDTH-bit
//   result is returned over a second valid/ready handshake. The opcode encoding
//   matches the parallel gate set: 0 NOT, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR,
//   6 XNOR, 7 invalid (completes at once with err set and out = 0).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand/opcode offer
//   in_ready   unit can accept (IDLE and rst low)
//   op         opcode (3 bits)
//   in1, in2   operands A and B (in2 ignored for NOT)
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   out        result register
//   err        result belongs to an invalid opcode, qualified by out_valid
//   busy       unit is not idle
module bit_serial_logic_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             err,
  output logic             busy
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("bit_serial_logic_unit: WIDTH must be in the range 2..32");
  end

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             load;

  // The single shared one-bit gate slice.
  function automatic logic gate_slice(input logic [2:0] f, input logic a, input logic b);
    logic r;
    case (f)
      3'd0:    r = ~a;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = a ^ b;
      3'd6:    r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load  = 1'b1;
          out_d = '0;
          cnt_d = '0;
          if (op == 3'd7) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        out_d[cnt_q] = gate_slice(op_q, a_q[cnt_q], b_q[cnt_q]);
        // The counter parks on the last bit instead of wrapping.
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Operand latches carry no reset: they are only read after a fresh load.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q  <= in1;
      b_q  <= in2;
      op_q <= op;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bit_serial_logic_unit.sv
module tb_bit_serial_logic_unit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         err;
  logic         busy;

  int nvec = 0;
  int nfail = 0;

  bit_serial_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    case (f)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] lowmask(input int k);
    logic [31:0] m;
    m = (k >= 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
    return m[W-1:0];
  endfunction

  // Transaction-level model: remembers the whole expected result and how many
  // result bits have been produced so far.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t      m_ph = M_IDLE;
  int           m_k = 0;
  logic [W-1:0] m_exp = '0;
  logic         m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = M_IDLE;
    end else begin
      case (m_ph)
        M_IDLE: if (in_valid) begin
          m_exp = ref_op(op, in1, in2);
          m_err = (op == 3'd7);
          m_k   = 0;
          m_ph  = (op == 3'd7) ? M_DONE : M_RUN;
        end
        M_RUN: begin
          m_k++;
          if (m_k == W) m_ph = M_DONE;
        end
        M_DONE: if (out_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Observation of handshakes at the clock edge.
  int           cyc = 0;
  int           acc_q[$];
  int           res_cyc_q[$];
  logic [W-1:0] res_out_q[$];
  logic         res_err_q[$];
  int           rise_q[$];
  int           rd_idx = 0;
  logic         ov_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    if (!rst && out_valid && out_ready) begin
      res_cyc_q.push_back(cyc);
      res_out_q.push_back(out);
      res_err_q.push_back(err);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", in_ready, (m_ph == M_IDLE) && !rst);
    check("busy", busy, m_ph != M_IDLE);
    check("out_valid", out_valid, m_ph == M_DONE);
    if (rst) begin
      check("rst_out", out, 0);
      check("rst_err", err, 0);
    end else if (m_ph == M_RUN) begin
      check("run_partial_out", out, m_exp & lowmask(m_k));
    end else if (m_ph == M_DONE) begin
      check("done_out", out, m_exp);
      check("done_err", err, m_err);
    end
    if (out_valid && !ov_prev) rise_q.push_back(cyc);
    ov_prev = out_valid;
  end

  task automatic wait_accepts(input int target);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_q.size() >= target) got = 1;
    end
    check("accept_timeout", got, 1);
  endtask

  task automatic offer(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n0;
    n0 = acc_q.size();
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    wait_accepts(n0 + 1);
    in_valid = 1'b0;
    // Scrambled inputs after the accept must have no effect.
    in1 = W'($urandom); in2 = W'($urandom); op = 3'($urandom);
  endtask

  task automatic wait_result(output logic [W-1:0] r, output logic e, output int hs);
    bit got = 0;
    r = '0; e = 1'b0; hs = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #1;
      if (res_out_q.size() > rd_idx) got = 1;
    end
    check("result_timeout", got, 1);
    if (got) begin
      r = res_out_q[rd_idx]; e = res_err_q[rd_idx]; hs = res_cyc_q[rd_idx];
      rd_idx++;
    end
  endtask

  initial begin
    logic [W-1:0] r;
    logic         e;
    int           hs, a0, n_acc, base;
    bit           got;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready_after_reset", in_ready, 1);

    // Model pins.
    check("model_and", ref_op(3'd1, 4'b1100, 4'b1010), 4'b1000);
    check("model_xnor", ref_op(3'd6, 4'b0101, 4'b0011), 4'b1001);

    // AND
    out_ready = 1'b1;
    offer(3'd1, 4'b1100, 4'b1010);
    a0 = acc_q[acc_q.size()-1];
    wait_result(r, e, hs);
    check("and_out", r, 4'b1000);
    check("and_err", e, 0);
    check("and_valid_latency", rise_q[rise_q.size()-1] - a0, W);
    check("and_consume_edge", hs - a0, W + 1);
    check("and_back_idle_ready", in_ready, 1);

    // NOT: in2 has no influence
    offer(3'd0, 4'b0110, 4'b1111);
    wait_result(r, e, hs);
    check("not_out_b1111", r, 4'b1001);
    offer(3'd0, 4'b0110, 4'b0000);
    wait_result(r, e, hs);
    check("not_out_b0000", r, 4'b1001);

    // XNOR with backpressure
    out_ready = 1'b0;
    offer(3'd6, 4'b0101, 4'b0011);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) got = 1;
    end
    check("xnor_valid_timeout", got, 1);
    n_acc = acc_q.size();
    op = 3'd1; in1 = 4'hF; in2 = 4'hF; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_out", out, 4'b1001);
      check("stall_ready", in_ready, 0);
    end
    check("stall_no_accept", acc_q.size(), n_acc);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_result(r, e, hs);
    check("xnor_out", r, 4'b1001);
    check("xnor_err", e, 0);
    repeat (3) @(posedge clk);
    #1;
    check("xnor_consumed_once", res_out_q.size(), rd_idx);

    // Invalid opcode
    offer(3'd7, 4'hF, 4'hF);
    a0 = acc_q[acc_q.size()-1];
    wait_result(r, e, hs);
    check("inv_out", r, 4'b0000);
    check("inv_err", e, 1);
    check("inv_valid_at_accept_edge", rise_q[rise_q.size()-1], a0);
    offer(3'd1, 4'hF, 4'hF);
    wait_result(r, e, hs);
    check("after_inv_out", r, 4'hF);
    check("after_inv_err", e, 0);

    // Reset mid-RUN
    offer(3'd5, 4'b1111, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    n_acc = acc_q.size();
    rst = 1'b1;
    in_valid = 1'b1; op = 3'd2; in1 = 4'b0001; in2 = 4'b0100;
    #2;
    check("rst_async_out", out, 0);
    check("rst_async_valid", out_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_accept", acc_q.size(), n_acc);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_no_result", res_out_q.size(), rd_idx);
    offer(3'd2, 4'b0001, 4'b0100);
    wait_result(r, e, hs);
    check("or_after_rst", r, 4'b0101);
    check("or_after_rst_err", e, 0);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    base = acc_q.size();
    op = 3'd1; in1 = 4'b1100; in2 = 4'b1010; in_valid = 1'b1;
    wait_accepts(base + 1);
    op = 3'd2;
    wait_accepts(base + 2);
    op = 3'd5;
    wait_accepts(base + 3);
    in_valid = 1'b0;
    if (acc_q.size() >= base + 3) begin
      check("b2b_spacing_1", acc_q[base+1] - acc_q[base], W + 2);
      check("b2b_spacing_2", acc_q[base+2] - acc_q[base+1], W + 2);
    end
    wait_result(r, e, hs);
    check("b2b_res0", r, 4'b1000);
    wait_result(r, e, hs);
    check("b2b_res1", r, 4'b1110);
    wait_result(r, e, hs);
    check("b2b_res2", r, 4'b0110);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
